// File: rtl/jtcolmix_palbright.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : jtcolmix_palbright
//  Purpose  : Palette RAM plus arithmetic brightness / shadow / highlight
//             back-end for Konami-style colour mixers. A power-up engine wipes
//             the palette, then a five-state sequencer resolves each pixel
//             through one time-shared multiplier and delivers blanked RGB888.
//  Revision : 1.0 - initial release
// ============================================================================
module jtcolmix_palbright #(
  parameter int AW = 11,  // palette address width
  parameter int CW = 5,   // bits per colour channel in a palette word (4..5)
  parameter int BW = 4    // brightness code width
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  input  logic          lhbl,
  input  logic          lvbl,
  // CPU side
  input  logic          pal_cs,
  input  logic          cpu_we,
  input  logic [1:0]    cpu_dsn,
  input  logic [AW-1:0] cpu_addr,
  input  logic [15:0]   cpu_dout,
  output logic [15:0]   cpu_din,
  // pixel side
  input  logic [AW-1:0] pxl_addr,
  input  logic [BW-1:0] bright,
  input  logic          shadow,
  input  logic          highlt,
  input  logic          bypass,
  // status and video out
  output logic          busy,
  output logic          ovr,
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue
);

  localparam int c_DEPTH = 1 << AW;
  localparam int c_PW    = 8 + BW + 1;  // product width: no intermediate wraps
  localparam int c_XW    = 8 - CW;      // bits replicated during expansion

  typedef enum logic [0:0] {
    CLR_WIPE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_t;

  typedef enum logic [2:0] {
    SQ_IDLE = 3'd0,
    SQ_LOAD = 3'd1,
    SQ_R    = 3'd2,
    SQ_G    = 3'd3,
    SQ_B    = 3'd4
  } seq_state_t;

  // --------------------------------------------------------------------------
  // Storage and state
  // --------------------------------------------------------------------------
  logic [15:0]     r_mem [c_DEPTH];
  logic [15:0]     r_ram_q;      // pixel read port output
  logic [15:0]     r_cpu_q;      // CPU read port output

  clr_state_t      r_clr_state, w_clr_next;
  logic [AW-1:0]   r_clr_addr;
  logic            w_run;

  seq_state_t      r_seq, w_seq_next;
  logic            w_capture;
  logic            w_overrun;

  logic [3*CW-1:0] r_word;
  logic [BW-1:0]   r_bright;
  logic            r_shadow;
  logic            r_highlt;
  logic            r_bypass;

  logic [7:0]      r_stg_r, r_stg_g, r_stg_b;
  logic [7:0]      r_red, r_green, r_blue;
  logic            r_hbl_d, r_vbl_d;
  logic            r_ovr;

  // write port mux
  logic [AW-1:0]   w_wr_addr;
  logic [15:0]     w_wr_data;
  logic            w_wr_lo, w_wr_hi;

  // channel arithmetic
  logic [CW-1:0]   w_chan;
  logic [7:0]      w_c8;
  logic [c_PW-1:0] w_mul_a, w_mul_b, w_prod, w_scaled;
  logic [7:0]      w_y_base;
  logic [c_PW-1:0] w_inv, w_half_up;
  logic [7:0]      w_y;
  logic            w_unused;

  assign w_run   = (r_clr_state == CLR_RUN);
  assign busy    = ~w_run;
  assign ovr     = r_ovr;
  assign red     = r_red;
  assign green   = r_green;
  assign blue    = r_blue;
  // the read register keeps sampling during the wipe; hide it until RUN
  assign cpu_din = w_run ? r_cpu_q : 16'd0;

  // --------------------------------------------------------------------------
  // Palette clear engine
  // --------------------------------------------------------------------------

  // clear FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_clr_state <= CLR_WIPE;
    else        r_clr_state <= w_clr_next;
  end

  // leave the wipe once the last entry has been written
  always_comb begin
    w_clr_next = r_clr_state;
    if (r_clr_state == CLR_WIPE && r_clr_addr == {AW{1'b1}})
      w_clr_next = CLR_RUN;
  end

  // wipe address walks the whole palette once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_clr_addr <= '0;
    else if (r_clr_state == CLR_WIPE) r_clr_addr <= r_clr_addr + AW'(1);
  end

  // single write port: the wipe owns it until RUN, CPU writes are dropped
  always_comb begin
    w_wr_addr = r_clr_addr;
    w_wr_data = 16'd0;
    w_wr_lo   = 1'b1;
    w_wr_hi   = 1'b1;
    if (w_run) begin
      w_wr_addr = cpu_addr;
      w_wr_data = cpu_dout;
      w_wr_lo   = pal_cs & cpu_we & ~cpu_dsn[0];
      w_wr_hi   = pal_cs & cpu_we & ~cpu_dsn[1];
    end
  end

  // palette RAM: byte-lane writes, two read-before-write read ports
  always_ff @(posedge clk) begin
    if (w_wr_lo) r_mem[w_wr_addr][7:0]  <= w_wr_data[7:0];
    if (w_wr_hi) r_mem[w_wr_addr][15:8] <= w_wr_data[15:8];
    r_ram_q <= r_mem[pxl_addr];
    r_cpu_q <= r_mem[cpu_addr];
  end

  // --------------------------------------------------------------------------
  // Pixel sequencer
  // --------------------------------------------------------------------------
  assign w_capture = pxl_cen & w_run & (r_seq == SQ_IDLE);
  assign w_overrun = pxl_cen & w_run & (r_seq != SQ_IDLE);

  // sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_seq <= SQ_IDLE;
    else        r_seq <= w_seq_next;
  end

  // IDLE -> LOAD on a captured pixel, then one colour channel per clk
  always_comb begin
    w_seq_next = r_seq;
    case (r_seq)
      SQ_IDLE: if (w_capture) w_seq_next = SQ_LOAD;
      SQ_LOAD: w_seq_next = SQ_R;
      SQ_R:    w_seq_next = SQ_G;
      SQ_G:    w_seq_next = SQ_B;
      SQ_B:    w_seq_next = SQ_IDLE;
      default: w_seq_next = SQ_IDLE;
    endcase
  end

  // capture per-pixel controls and latch the palette word one clk later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bright <= '0;
      r_shadow <= 1'b0;
      r_highlt <= 1'b0;
      r_bypass <= 1'b0;
      r_word   <= '0;
    end else begin
      if (w_capture) begin
        r_bright <= bright;
        r_shadow <= shadow;
        r_highlt <= highlt;
        r_bypass <= bypass;
      end
      if (r_seq == SQ_LOAD) r_word <= r_ram_q[3*CW-1:0];
    end
  end

  // channel select for the shared multiplier
  always_comb begin
    w_chan = r_word[CW-1:0];
    case (r_seq)
      SQ_G:    w_chan = r_word[2*CW-1:CW];
      SQ_B:    w_chan = r_word[3*CW-1:2*CW];
      default: w_chan = r_word[CW-1:0];
    endcase
  end

  // expand by MSB replication, scale, then apply shadow/highlight/bypass
  always_comb begin
    w_c8      = {w_chan, w_chan[CW-1 -: c_XW]};
    w_mul_a   = c_PW'(w_c8);
    w_mul_b   = c_PW'(r_bright) + c_PW'(1);
    w_prod    = w_mul_a * w_mul_b;
    w_scaled  = w_prod >> BW;
    w_y_base  = w_scaled[7:0];
    w_inv     = c_PW'(8'd255) - c_PW'(w_y_base);
    w_half_up = c_PW'(w_y_base) + (w_inv >> 1);
    if (r_bypass)      w_y = w_c8;
    else if (r_shadow) w_y = w_y_base >> 1;  // shadow beats highlight
    else if (r_highlt) w_y = w_half_up[7:0];
    else               w_y = w_y_base;
  end

  // results never exceed 8 bits; upper intermediate bits are headroom only
  assign w_unused = ^{w_scaled[c_PW-1:8], w_half_up[c_PW-1:8], r_ram_q[15:3*CW]};

  // staging registers, one channel per sequencer step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg_r <= 8'd0;
      r_stg_g <= 8'd0;
      r_stg_b <= 8'd0;
    end else begin
      if (r_seq == SQ_R) r_stg_r <= w_y;
      if (r_seq == SQ_G) r_stg_g <= w_y;
      if (r_seq == SQ_B) r_stg_b <= w_y;
    end
  end

  // --------------------------------------------------------------------------
  // Output stage
  // --------------------------------------------------------------------------

  // blanks travel alongside the pixel: sampled with it, applied on the load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hbl_d <= 1'b0;
      r_vbl_d <= 1'b0;
      r_red   <= 8'd0;
      r_green <= 8'd0;
      r_blue  <= 8'd0;
    end else if (pxl_cen) begin
      r_hbl_d <= lhbl;
      r_vbl_d <= lvbl;
      if (w_run && r_hbl_d && r_vbl_d) begin
        r_red   <= r_stg_r;
        r_green <= r_stg_g;
        r_blue  <= r_stg_b;
      end else begin
        r_red   <= 8'd0;
        r_green <= 8'd0;
        r_blue  <= 8'd0;
      end
    end
  end

  // sticky overrun: a pixel strobe arrived before the previous one finished
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_ovr <= 1'b0;
    else if (w_overrun) r_ovr <= 1'b1;
  end

endmodule
`default_nettype wire

// File: tb/tb_jtcolmix_palbright.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_jtcolmix_palbright
//  Purpose  : Directed, table-driven bench for jtcolmix_palbright.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jtcolmix_palbright;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pxl_cen = 1'b0;
  logic        lhbl = 1'b1;
  logic        lvbl = 1'b1;
  logic        pal_cs = 1'b0;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_dsn = 2'b11;
  logic [10:0] cpu_addr = '0;
  logic [15:0] cpu_dout = '0;
  logic [15:0] cpu_din;
  logic [10:0] pxl_addr = '0;
  logic [3:0]  bright = 4'd15;
  logic        shadow = 1'b0;
  logic        highlt = 1'b0;
  logic        bypass = 1'b0;
  logic        busy, ovr;
  logic [7:0]  red, green, blue;

  int n_pass = 0;
  int n_tot  = 0;
  int cen_per = 6;

  jtcolmix_palbright #(.AW(11), .CW(5), .BW(4)) dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .lhbl(lhbl), .lvbl(lvbl),
    .pal_cs(pal_cs), .cpu_we(cpu_we), .cpu_dsn(cpu_dsn), .cpu_addr(cpu_addr),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .pxl_addr(pxl_addr),
    .bright(bright), .shadow(shadow), .highlt(highlt), .bypass(bypass),
    .busy(busy), .ovr(ovr), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  // pixel strobe: one clk high every cen_per clocks, changed on negedges
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (cnt >= cen_per - 1) begin
        pxl_cen = 1'b1;
        cnt = 0;
      end else begin
        pxl_cen = 1'b0;
        cnt++;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // returns 1 clk after an active pxl_cen edge
  task automatic wait_cen();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!pxl_cen && n < 100);
    if (!pxl_cen) begin
      n_tot++;
      $display("FAIL wait_cen: no pixel strobe within %0d clk", n);
    end
    #1;
  endtask

  task automatic cpu_write(input logic [10:0] a, input logic [15:0] d, input logic [1:0] dsn);
    @(negedge clk);
    pal_cs = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_dout = d; cpu_dsn = dsn;
    @(negedge clk);
    pal_cs = 1'b0; cpu_we = 1'b0; cpu_dsn = 2'b11;
  endtask

  task automatic cpu_read(input logic [10:0] a, output logic [15:0] d);
    @(negedge clk);
    cpu_addr = a;
    @(posedge clk);
    #1 d = cpu_din;
  endtask

  typedef struct {
    logic [10:0] addr;
    logic [3:0]  br;
    logic        sh, hl, bp, hb, vb;
    logic [7:0]  er, eg, eb;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [15:0] rd;
    int cnt;
    logic clr_bad;

    //            addr    br  sh hl bp hb vb   R      G      B
    vecs[0]  = '{11'h010, 15, 0, 0, 0, 1, 1, 8'h00, 8'h00, 8'hFF};
    vecs[1]  = '{11'h010,  7, 0, 0, 0, 1, 1, 8'h00, 8'h00, 8'h7F};
    vecs[2]  = '{11'h010,  7, 1, 0, 0, 1, 1, 8'h00, 8'h00, 8'h3F};
    vecs[3]  = '{11'h010,  7, 0, 1, 0, 1, 1, 8'h7F, 8'h7F, 8'hBF};
    vecs[4]  = '{11'h010,  7, 1, 1, 0, 1, 1, 8'h00, 8'h00, 8'h3F};
    vecs[5]  = '{11'h010,  7, 0, 0, 1, 1, 1, 8'h00, 8'h00, 8'hFF};
    vecs[6]  = '{11'h011, 15, 0, 0, 0, 1, 1, 8'hFF, 8'h00, 8'h00};
    vecs[7]  = '{11'h012, 15, 0, 0, 0, 1, 1, 8'h00, 8'hFF, 8'h00};
    vecs[8]  = '{11'h013, 15, 0, 0, 0, 1, 1, 8'h84, 8'h84, 8'h84};
    vecs[9]  = '{11'h013,  7, 0, 0, 0, 1, 1, 8'h42, 8'h42, 8'h42};
    vecs[10] = '{11'h013,  7, 1, 0, 0, 1, 1, 8'h21, 8'h21, 8'h21};
    vecs[11] = '{11'h013, 15, 0, 1, 0, 1, 1, 8'hC1, 8'hC1, 8'hC1};
    vecs[12] = '{11'h014, 15, 0, 0, 0, 1, 1, 8'h08, 8'h08, 8'h08};
    vecs[13] = '{11'h014,  0, 0, 0, 0, 1, 1, 8'h00, 8'h00, 8'h00};
    vecs[14] = '{11'h014,  0, 0, 1, 0, 1, 1, 8'h7F, 8'h7F, 8'h7F};
    vecs[15] = '{11'h010, 15, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00};

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd1);
    check("reset_ovr", 32'(ovr), 32'd0);
    check("reset_rgb", {8'd0, red, green, blue}, 32'd0);
    check("reset_cpu_din", 32'(cpu_din), 32'd0);

    // ---------------- palette clear ----------------
    rst_n = 1'b1;
    cnt = 0;
    clr_bad = 1'b0;
    while (busy && cnt < 5000) begin
      cnt++;
      if (cpu_din !== 16'd0 || {red, green, blue} !== 24'd0) clr_bad = 1'b1;
      if (cnt == 100) begin
        pal_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h010;
        cpu_dout = 16'hABCD; cpu_dsn = 2'b00;
      end
      if (cnt == 101) begin
        pal_cs = 1'b0; cpu_we = 1'b0; cpu_dsn = 2'b11;
      end
      @(negedge clk);
    end
    check("clear_cycles", 32'(cnt), 32'd2048);
    check("clear_outputs_zero", 32'(clr_bad), 32'd0);
    cpu_read(11'h010, rd);
    check("clear_write_dropped", 32'(rd), 32'd0);

    // ---------------- palette contents ----------------
    cpu_write(11'h010, 16'h7C00, 2'b00);
    cpu_write(11'h011, 16'h001F, 2'b00);
    cpu_write(11'h012, 16'h03E0, 2'b00);
    cpu_write(11'h013, 16'h4210, 2'b00);
    cpu_write(11'h014, 16'h8421, 2'b00);
    cpu_read(11'h010, rd);
    check("readback_010", 32'(rd), 32'h7C00);
    cpu_read(11'h014, rd);
    check("readback_014", 32'(rd), 32'h8421);

    // ---------------- byte lanes ----------------
    cpu_write(11'h020, 16'hFFFF, 2'b10);
    cpu_read(11'h020, rd);
    check("lane_low", 32'(rd), 32'h00FF);
    cpu_write(11'h020, 16'h1200, 2'b01);
    cpu_read(11'h020, rd);
    check("lane_high", 32'(rd), 32'h12FF);

    // ---------------- pixel vectors ----------------
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pxl_addr = vecs[i].addr; bright = vecs[i].br;
      shadow = vecs[i].sh; highlt = vecs[i].hl; bypass = vecs[i].bp;
      lhbl = vecs[i].hb; lvbl = vecs[i].vb;
      wait_cen();
      wait_cen();
      check($sformatf("vec%0d_rgb", i), {8'd0, red, green, blue},
            {8'd0, vecs[i].er, vecs[i].eg, vecs[i].eb});
    end
    check("no_ovr_at_period6", 32'(ovr), 32'd0);

    // ---------------- lhbl one-period pulse ----------------
    @(negedge clk);
    pxl_addr = 11'h010; bright = 4'd15; shadow = 0; highlt = 0; bypass = 0;
    lhbl = 1'b1; lvbl = 1'b1;
    wait_cen();
    wait_cen();
    lhbl = 1'b0;
    wait_cen();
    lhbl = 1'b1;
    check("blank_before", {8'd0, red, green, blue}, 32'h0000_00FF);
    wait_cen();
    check("blank_hit", {8'd0, red, green, blue}, 32'd0);
    wait_cen();
    check("blank_after", {8'd0, red, green, blue}, 32'h0000_00FF);

    // ---------------- CPU write colliding with pixel read ----------------
    wait_cen();
    repeat (6) @(negedge clk);
    pal_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h010;
    cpu_dout = 16'h001F; cpu_dsn = 2'b00;
    @(negedge clk);
    pal_cs = 1'b0; cpu_we = 1'b0; cpu_dsn = 2'b11;
    wait_cen();
    check("collide_old_data", {8'd0, red, green, blue}, 32'h0000_00FF);
    wait_cen();
    check("collide_new_data", {8'd0, red, green, blue}, 32'h00FF_0000);
    cpu_read(11'h010, rd);
    check("collide_write_done", 32'(rd), 32'h001F);

    // ---------------- overrun ----------------
    wait_cen();
    cen_per = 3;
    check("ovr_before", 32'(ovr), 32'd0);
    wait_cen();
    check("ovr_set", 32'(ovr), 32'd1);
    repeat (4) wait_cen();
    cen_per = 6;
    repeat (3) wait_cen();
    check("ovr_sticky", 32'(ovr), 32'd1);

    // ---------------- reset clears everything ----------------
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst2_ovr", 32'(ovr), 32'd0);
    check("rst2_busy", 32'(busy), 32'd1);
    check("rst2_rgb", {8'd0, red, green, blue}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (busy && cnt < 5000) begin
      cnt++;
      @(negedge clk);
    end
    check("rst2_clear_cycles", 32'(cnt), 32'd2048);
    cpu_read(11'h010, rd);
    check("rst2_palette_wiped", 32'(rd), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
